// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Optional error flags are enabled by defining FIFO_ERR_FLAGS_EN.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic threshold;
    logic almost_empty;
  } fifo_status_t;

  // Address width for a power-of-two depth: smallest aw with 2**aw >= depth.
  function automatic int fifo_aw(int depth);
    int aw;
    aw = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) aw = i + 1;
    end
    return aw;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// One AW+1-bit FIFO pointer (extra wrap bit) with increment enable and synchronous flush.
// Used for both the write and the read side of param_sync_fifo.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        flush_i,
  output logic [AW:0] ptr_o
);

  logic [AW:0] ptr_q;
  logic [AW:0] ptr_d;

  // NOTE: a default assignment before any branch keeps this purely combinational (no latch).
  always_comb begin
    ptr_d = ptr_q;
    if (flush_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised first-word-fall-through FIFO with fill level, almost-full/empty and flush.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr,
  input  logic [DW-1:0]              data_fifo,
  input  logic                       mstr0_ready,
  output logic [DW-1:0]              mstr0_data,
  output logic                       data_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       fifo_threshold,
  output logic                       almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                       err_clr,
  output logic                       ovf_err,
  output logic                       udf_err,
`endif
  output logic [fifo_aw(DEPTH):0]    fill_level
);

  localparam int AW = fifo_aw(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL = (AW+1)'(AE_LEVEL);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          we;
  logic          re;
  fifo_status_t  status;
  logic [DW-1:0] mem_q [DEPTH];

  // Status comes only from registered pointers and level, so it never glitches on inputs.
  always_comb begin
    status.full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    status.empty        = (wptr == rptr);
    status.threshold    = (level_q >= AF_LVL);
    status.almost_empty = (level_q <= AE_LVL);
  end

  // Flush wins over both sides; full blocks writes even when a read frees a slot this cycle.
  assign we = wr & ~status.full & ~flush;
  assign re = mstr0_ready & ~status.empty & ~flush;

  fifo_ptr_ctrl #(.AW(AW)) u_wptr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (we),
    .flush_i(flush),
    .ptr_o  (wptr)
  );

  fifo_ptr_ctrl #(.AW(AW)) u_rptr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (re),
    .flush_i(flush),
    .ptr_o  (rptr)
  );

  // NOTE: storage is deliberately not reset; empty/data_valid gate its contents after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wptr[AW-1:0]] <= data_fifo;
    end
  end

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      case ({we, re})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic ovf_d;
  logic udf_q;
  logic udf_d;
  logic ovf_evt;
  logic udf_evt;

  assign ovf_evt = wr & status.full & ~flush;
  assign udf_evt = mstr0_ready & status.empty & ~flush;

  // A new event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end
    if (udf_evt) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif

  assign mstr0_data     = mem_q[rptr[AW-1:0]];
  assign data_valid     = ~status.empty;
  assign fifo_full      = status.full;
  assign fifo_empty     = status.empty;
  assign fifo_threshold = status.threshold;
  assign almost_empty   = status.almost_empty;
  assign fill_level     = level_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: directed scenarios followed by randomized traffic.
// Build with FIFO_ERR_FLAGS_EN defined to also check the sticky error flags.
module tb_param_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr;
  logic [DW-1:0] data_fifo;
  logic          mstr0_ready;
  logic [DW-1:0] mstr0_data;
  logic          data_valid;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_threshold;
  logic          almost_empty;
  logic [AW:0]   fill_level;
`ifdef FIFO_ERR_FLAGS_EN
  logic          err_clr;
  logic          ovf_err;
  logic          udf_err;
  bit            mdl_ovf;
  bit            mdl_udf;
`endif

  int            n_tests = 0;
  int            n_fail  = 0;
  int            mdl_level = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wr            (wr),
    .data_fifo     (data_fifo),
    .mstr0_ready   (mstr0_ready),
    .mstr0_data    (mstr0_data),
    .data_valid    (data_valid),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_threshold(fifo_threshold),
    .almost_empty  (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr       (err_clr),
    .ovf_err       (ovf_err),
    .udf_err       (udf_err),
`endif
    .fill_level    (fill_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then advance the reference model by that cycle's accepted traffic.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    bit we_m;
    bit re_m;
    wr = w; data_fifo = d; mstr0_ready = r; flush = f;
    @(posedge clk);
    we_m = w && (mdl_level < DEPTH) && !f;
    re_m = r && (mdl_level > 0) && !f;
`ifdef FIFO_ERR_FLAGS_EN
    if (w && mdl_level == DEPTH && !f) mdl_ovf = 1'b1;
    else if (err_clr) mdl_ovf = 1'b0;
    if (r && mdl_level == 0 && !f) mdl_udf = 1'b1;
    else if (err_clr) mdl_udf = 1'b0;
`endif
    if (f) begin
      mdl_level = 0;
      exp_q.delete();
    end else begin
      if (we_m) exp_q.push_back(d);
      mdl_level = mdl_level + int'(we_m) - int'(re_m);
    end
    #1;
  endtask

  task automatic model_reset();
    mdl_level = 0;
    exp_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
`endif
  endtask

  // Monitor: checks status each cycle and pops the scoreboard on every accepted read.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (!rst) begin
      check("fill_level", 64'(fill_level), 64'(mdl_level));
      check("data_valid", 64'(data_valid), 64'(mdl_level != 0));
      check("fifo_empty", 64'(fifo_empty), 64'(mdl_level == 0));
      check("fifo_full", 64'(fifo_full), 64'(mdl_level == DEPTH));
      check("threshold", 64'(fifo_threshold), 64'(mdl_level >= AF));
      check("almost_empty", 64'(almost_empty), 64'(mdl_level <= AE));
`ifdef FIFO_ERR_FLAGS_EN
      check("ovf_err", 64'(ovf_err), 64'(mdl_ovf));
      check("udf_err", 64'(udf_err), 64'(mdl_udf));
`endif
      if (data_valid && mstr0_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(data_valid), 64'(0));
        end else begin
          exp_d = exp_q.pop_front();
          check("rd_data", 64'(mstr0_data), 64'(exp_d));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wr = 1'b0; data_fifo = '0; mstr0_ready = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_fill_level", 64'(fill_level), 64'(0));
    check("rst_empty", 64'(fifo_empty), 64'(1));
    check("rst_valid", 64'(data_valid), 64'(0));
    check("rst_full", 64'(fifo_full), 64'(0));
    check("rst_threshold", 64'(fifo_threshold), 64'(0));
    check("rst_almost_empty", 64'(almost_empty), 64'(1));

    // Fill, overflow attempt, drain; twice so the wrap bit toggles.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b1, DW'(i), 1'b0, 1'b0);
        check("fill_thr", 64'(fifo_threshold), 64'(i + 1 >= AF));
      end
      check("fill_full", 64'(fifo_full), 64'(1));
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      check("ovf_level", 64'(fill_level), 64'(DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
      check("ovf_flag", 64'(ovf_err), 64'(1));
      err_clr = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      err_clr = 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b0, '0, 1'b1, 1'b0);
        check("drain_ae", 64'(almost_empty), 64'(DEPTH - 1 - i <= AE));
      end
      check("drain_empty", 64'(fifo_empty), 64'(1));
    end

    // Full with simultaneous write and read: read only.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b1, 1'b0);
    check("full_rw_level", 64'(fill_level), 64'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Empty with simultaneous write and read: write only, visible next cycle.
    step(1'b1, 32'h0000_00AB, 1'b1, 1'b0);
    check("empty_rw_level", 64'(fill_level), 64'(1));
    check("empty_rw_data", 64'(mstr0_data), 64'h0000_00AB);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush at level 7 with a concurrent write.
    for (int i = 0; i < 7; i++) step(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b0, 1'b1);
    check("flush_level", 64'(fill_level), 64'(0));
    check("flush_empty", 64'(fifo_empty), 64'(1));
`ifdef FIFO_ERR_FLAGS_EN
    check("flush_no_ovf", 64'(ovf_err), 64'(0));
    check("flush_no_udf", 64'(udf_err), 64'(0));

    // Sticky underflow: set, hold, set-beats-clear, clear.
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_set", 64'(udf_err), 64'(1));
    step(1'b0, '0, 1'b0, 1'b0);
    check("udf_hold", 64'(udf_err), 64'(1));
    err_clr = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_set_wins", 64'(udf_err), 64'(1));
    step(1'b0, '0, 1'b0, 1'b0);
    check("udf_clr", 64'(udf_err), 64'(0));
    err_clr = 1'b0;
`endif

    // Randomized traffic with alternating fill/drain bias.
    for (int c = 0; c < 3000; c++) begin
      int wp;
      wp = ((c / 200) % 2 == 0) ? 75 : 30;
`ifdef FIFO_ERR_FLAGS_EN
      err_clr = ($urandom_range(0, 99) < 5);
`endif
      step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 2);
    end
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif

    // Asynchronous reset mid-stream with 5 entries held.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
    wr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_empty", 64'(fifo_empty), 64'(1));
    check("async_rst_level", 64'(fill_level), 64'(0));
    check("async_rst_valid", 64'(data_valid), 64'(0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 32'h0000_0777, 1'b0, 1'b0);
    check("post_rst_data", 64'(mstr0_data), 64'h0000_0777);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
